// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-1024x8-SRAM bridge.
package sram_bridge_pkg;
  localparam int SRAM_AW = 10;
  localparam int SRAM_DW = 8;
  localparam int LANES   = 4;

  // Bit write enables are active low: all-zero enables every bit.
  localparam logic [SRAM_DW-1:0] WEN_ALL  = 8'h00;
  localparam logic [SRAM_DW-1:0] WEN_NONE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    ACK    = 2'd3
  } state_t;
endpackage

// File: rtl/sram_bridge_stats.sv
// Two saturating 16-bit transaction counters: {writes, reads}.
module sram_bridge_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_inc,
  input  logic        rd_inc,
  output logic [31:0] stat
);
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= 16'h0000;
      rd_cnt <= 16'h0000;
    end else begin
      if (wr_inc && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      if (rd_inc && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
    end
  end

  assign stat = {wr_cnt, rd_cnt};
endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone slave serialising 32-bit accesses into byte cycles on a 1024x8 SRAM.
// Optional statistics counters are built when SRAM_BRIDGE_STATS_EN is defined.
module wb_sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic                sram_cen_n,
  output logic                sram_gwen_n,
  output logic [SRAM_DW-1:0]  sram_wen_n,
  output logic [SRAM_AW-1:0]  sram_a,
  output logic [SRAM_DW-1:0]  sram_d,
  input  logic [SRAM_DW-1:0]  sram_q,
  output logic [31:0]         stat_o,
  output state_t              dbg_state
);
  state_t       state, state_nxt;
  logic [1:0]   lane, lane_nxt;
  logic [7:0]   word_q;
  logic [31:0]  dat_q;
  logic [3:0]   sel_q;
  logic         we_q;
  logic         abort_q;
  logic [31:0]  rdata, rdata_nxt;
  logic         hit;
  logic         aborting;
  logic         cap_en;
  logic [1:0]   cap_lane;

  logic               cen_nxt, gwen_nxt;
  logic [SRAM_DW-1:0] wen_nxt, d_nxt;
  logic [SRAM_AW-1:0] a_nxt;
  logic [3:0]         src_sel;
  logic               src_we;
  logic [31:0]        src_dat;
  logic [7:0]         src_word;

  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];

  assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:10] == BASE_ADDR[31:10]);
  assign aborting = abort_q | ~wbs_cyc_i;

  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt = ACCESS;
          lane_nxt  = 2'd0;
        end
      end
      ACCESS: begin
        lane_nxt = lane + 2'd1;
        if (lane == 2'd3) state_nxt = we_q ? ACK : DRAIN;
      end
      DRAIN:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pins are registered, so compute what the next cycle drives; the first
  // lane is issued before the request fields have been latched.
  always_comb begin
    src_sel  = (state == IDLE) ? wbs_sel_i        : sel_q;
    src_we   = (state == IDLE) ? wbs_we_i         : we_q;
    src_dat  = (state == IDLE) ? wbs_dat_i        : dat_q;
    src_word = (state == IDLE) ? wbs_adr_i[9:2]   : word_q;
    cen_nxt  = 1'b1;
    gwen_nxt = 1'b1;
    wen_nxt  = WEN_NONE;
    a_nxt    = sram_a;
    d_nxt    = sram_d;
    if (state_nxt == ACCESS && src_sel[lane_nxt]) begin
      cen_nxt = 1'b0;
      a_nxt   = {src_word, lane_nxt};
      if (src_we) begin
        gwen_nxt = 1'b0;
        wen_nxt  = WEN_ALL;
        d_nxt    = src_dat[{lane_nxt, 3'b000} +: 8];
      end
    end
  end

  // A byte issued in one cycle returns in the next; in DRAIN the lane counter
  // has wrapped to 0, so lane-1 points at lane 3.
  assign cap_en   = (state == ACCESS && lane != 2'd0) || (state == DRAIN);
  assign cap_lane = lane - 2'd1;

  always_comb begin
    rdata_nxt = rdata;
    if (cap_en) rdata_nxt[{cap_lane, 3'b000} +: 8] = sel_q[cap_lane] ? sram_q : 8'h00;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      lane        <= 2'd0;
      word_q      <= 8'h00;
      dat_q       <= 32'h0;
      sel_q       <= 4'h0;
      we_q        <= 1'b0;
      abort_q     <= 1'b0;
      rdata       <= 32'h0;
      wbs_dat_o   <= 32'h0;
      sram_cen_n  <= 1'b1;
      sram_gwen_n <= 1'b1;
      sram_wen_n  <= WEN_NONE;
      sram_a      <= '0;
      sram_d      <= '0;
    end else begin
      state       <= state_nxt;
      lane        <= lane_nxt;
      rdata       <= rdata_nxt;
      sram_cen_n  <= cen_nxt;
      sram_gwen_n <= gwen_nxt;
      sram_wen_n  <= wen_nxt;
      sram_a      <= a_nxt;
      sram_d      <= d_nxt;
      if (state == IDLE && hit) begin
        word_q  <= wbs_adr_i[9:2];
        dat_q   <= wbs_dat_i;
        sel_q   <= wbs_sel_i;
        we_q    <= wbs_we_i;
        abort_q <= 1'b0;
      end else if ((state == ACCESS || state == DRAIN) && !wbs_cyc_i) begin
        abort_q <= 1'b1;
      end
      if (state == DRAIN && !aborting) wbs_dat_o <= rdata_nxt;
    end
  end

  assign wbs_ack_o = (state == ACK) & wbs_cyc_i & ~abort_q;
  assign dbg_state = state;

`ifdef SRAM_BRIDGE_STATS_EN
  sram_bridge_stats u_stats (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .wr_inc (wbs_ack_o & we_q),
    .rd_inc (wbs_ack_o & ~we_q),
    .stat   (stat_o)
  );
`else
  assign stat_o = 32'h0;
`endif
endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge with a behavioural 1024x8 SRAM model.
module tb_wb_sram_bridge;
  import sram_bridge_pkg::*;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        sram_cen_n, sram_gwen_n;
  logic [7:0]  sram_wen_n, sram_d, sram_q;
  logic [9:0]  sram_a;
  logic [31:0] stat_o;
  state_t      dbg_state;

  wb_sram_bridge dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .sram_cen_n(sram_cen_n), .sram_gwen_n(sram_gwen_n), .sram_wen_n(sram_wen_n),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q),
    .stat_o(stat_o), .dbg_state(dbg_state)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_cnt = 0;
  int cen_cnt = 0;
  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;
  always @(negedge wb_clk_i) if (!sram_cen_n) cen_cnt = cen_cnt + 1;

  // SRAM model: read data appears after the enabling edge.
  logic [7:0] mem [0:1023];
  logic [7:0] q_model = 8'h00;
  assign sram_q = q_model;
  always @(posedge wb_clk_i) begin
    if (!sram_cen_n) begin
      if (!sram_gwen_n) mem[sram_a] <= (mem[sram_a] & sram_wen_n) | (sram_d & ~sram_wen_n);
      else q_model <= mem[sram_a];
    end
  end

  int total = 0;
  int bad = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a request at the current time (a falling edge) and waits for ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit keep, output logic got,
                         output int lat, output logic [31:0] rd, output int cens);
    int start;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    start = cyc_cnt; cen_cnt = 0; got = 1'b0; lat = 0; rd = 32'h0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        got = 1'b1;
        lat = cyc_cnt - start;
        rd  = wbs_dat_o;
      end
    end
    cens = cen_cnt;
    if (!keep) begin
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    int          lat;
    logic [31:0] rd;
    int          cen;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic        got;
    int          lat, cens, start;
    logic [31:0] rd, hold;

    vecs[0]  = '{1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 5, 32'h0,         4};
    vecs[1]  = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 6, 32'hDEAD_BEEF, 4};
    vecs[2]  = '{1'b1, 32'h3000_0010, 32'h1122_3344, 4'h5, 1'b1, 5, 32'h0,         2};
    vecs[3]  = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 6, 32'hDE22_BE44, 4};
    vecs[4]  = '{1'b0, 32'h3000_0010, 32'h0,         4'h6, 1'b1, 6, 32'h0022_BE00, 2};
    vecs[5]  = '{1'b1, 32'h3000_0020, 32'hFFFF_FFFF, 4'h0, 1'b1, 5, 32'h0,         0};
    vecs[6]  = '{1'b0, 32'h3000_0020, 32'h0,         4'h0, 1'b1, 6, 32'h0,         0};
    vecs[7]  = '{1'b1, 32'h3000_0400, 32'h1234_5678, 4'hF, 1'b0, 0, 32'h0,         0};
    vecs[8]  = '{1'b1, 32'h3000_03FC, 32'hA5A5_5A5A, 4'hF, 1'b1, 5, 32'h0,         4};
    vecs[9]  = '{1'b0, 32'h3000_03FC, 32'h0,         4'hF, 1'b1, 6, 32'hA5A5_5A5A, 4};
    vecs[10] = '{1'b1, 32'h3000_0013, 32'h7700_0000, 4'h8, 1'b1, 5, 32'h0,         1};
    vecs[11] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 6, 32'h7722_BE44, 4};
    vecs[12] = '{1'b0, 32'h2000_0010, 32'h0,         4'hF, 1'b0, 0, 32'h0,         0};

    // Reset values
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_pins", {20'h0, sram_cen_n, sram_gwen_n, sram_wen_n, 2'b00}, {20'h0, 1'b1, 1'b1, 8'hFF, 2'b00});
    chk("rst_ad", {14'h0, sram_a, sram_d}, 32'h0);
    chk("rst_stat", stat_o, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, {30'h0, IDLE});
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge wb_clk_i);
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 1'b0, got, lat, rd, cens);
      chk($sformatf("v%0d_ack", i), {31'h0, got}, {31'h0, vecs[i].ack});
      if (vecs[i].ack) begin
        chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        if (vecs[i].we) exp_wr++; else exp_rd++;
        if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
      end
      chk($sformatf("v%0d_cen_cycles", i), 32'(cens), 32'(vecs[i].cen));
      @(posedge wb_clk_i); #1;
      chk($sformatf("v%0d_idle", i), {30'h0, dbg_state}, {30'h0, IDLE});
    end

    // Back-to-back: read hit sampled in the cycle right after the write ACK
    @(negedge wb_clk_i);
    wb_xfer(1'b1, 32'h3000_0060, 32'h0BAD_F00D, 4'hF, 1'b1, got, lat, rd, cens);
    chk("b2b_wr_lat", 32'(lat), 32'd5);
    wb_xfer(1'b0, 32'h3000_0060, 32'h0, 4'hF, 1'b0, got, lat, rd, cens);
    chk("b2b_rd_lat", 32'(lat), 32'd7);
    chk("b2b_rd_data", rd, 32'h0BAD_F00D);
    exp_wr++; exp_rd++;

    // Write abort: cyc drops in ACCESS cycle 2, returns (stb low) before ACK
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3000_0040; wbs_dat_i = 32'hCAFE_F00D; wbs_sel_i = 4'hF;
    start = cyc_cnt; cen_cnt = 0; got = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) got = 1'b1;
      if (c == 2) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
      if (c == 4) wbs_cyc_i = 1'b1;
      if (c == 6) chk("wabort_idle_c6", {30'h0, dbg_state}, {30'h0, IDLE});
      if (c == 7) wbs_cyc_i = 1'b0;
    end
    chk("wabort_no_ack", {31'h0, got}, 32'h0);
    chk("wabort_cen_cycles", 32'(cen_cnt), 32'd4);
    chk("wabort_mem", {mem[10'h043], mem[10'h042], mem[10'h041], mem[10'h040]}, 32'hCAFE_F00D);

    // Read abort: no ack and read data output holds
    hold = 32'h0BAD_F00D;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3000_0040; wbs_sel_i = 4'hF;
    got = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) got = 1'b1;
      if (c == 3) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
      if (c == 5) wbs_cyc_i = 1'b1;
      if (c == 8) wbs_cyc_i = 1'b0;
    end
    chk("rabort_no_ack", {31'h0, got}, 32'h0);
    chk("rabort_dat_hold", wbs_dat_o, hold);
    chk("rabort_idle", {30'h0, dbg_state}, {30'h0, IDLE});

    // Reset pulsed in ACCESS cycle 2
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3000_0050; wbs_dat_i = 32'h1234_5678; wbs_sel_i = 4'hF;
    start = cyc_cnt;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b0;
    #1;
    chk("mrst_ack", {31'h0, wbs_ack_o}, 32'h0);
    chk("mrst_dat", wbs_dat_o, 32'h0);
    chk("mrst_pins", {20'h0, sram_cen_n, sram_gwen_n, sram_wen_n, 2'b00}, {20'h0, 1'b1, 1'b1, 8'hFF, 2'b00});
    chk("mrst_ad", {14'h0, sram_a, sram_d}, 32'h0);
    chk("mrst_stat", stat_o, 32'h0);
    chk("mrst_state", {30'h0, dbg_state}, {30'h0, IDLE});
    exp_wr = 0; exp_rd = 0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    got = 1'b0;
    repeat (6) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) got = 1'b1;
    end
    chk("mrst_no_ack", {31'h0, got}, 32'h0);

    wb_xfer(1'b1, 32'h3000_0050, 32'h5566_7788, 4'hF, 1'b0, got, lat, rd, cens);
    chk("post_rst_wr_lat", 32'(lat), 32'd5);
    @(negedge wb_clk_i);
    wb_xfer(1'b0, 32'h3000_0050, 32'h0, 4'hF, 1'b0, got, lat, rd, cens);
    chk("post_rst_rd_lat", 32'(lat), 32'd6);
    chk("post_rst_rd_data", rd, 32'h5566_7788);
    exp_wr++; exp_rd++;

    // Final memory image and statistics
    @(negedge wb_clk_i);
    chk("mem_word4", {mem[10'h013], mem[10'h012], mem[10'h011], mem[10'h010]}, 32'h7722_BE44);
    chk("mem_word255", {mem[10'h3FF], mem[10'h3FE], mem[10'h3FD], mem[10'h3FC]}, 32'hA5A5_5A5A);
`ifdef SRAM_BRIDGE_STATS_EN
    chk("stat", stat_o, {exp_wr[15:0], exp_rd[15:0]});
`else
    chk("stat", stat_o, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
